// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control path.
//   - opcode constants for the supported instruction classes
//   - ALUOp encodings consumed by the downstream ALU control
//   - packed EX / M / WB control bundles and their all-zero bubble values
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // 2'b11 is never produced.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_t;

  localparam ex_t EX_BUBBLE = '0;
  localparam m_t  M_BUBBLE  = '0;
  localparam wb_t WB_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode decoder.
//   opcode : instr[31:26]
//   ex     : {RegDst, ALUOp[1:0], ALUSrc}
//   m      : {Branch, MemRead, MemWrite}
//   wb     : {RegWrite, MemtoReg}
// Unsupported opcodes decode to the all-zero bubble; don't-care fields are 0.
module ctrl_decode_comb
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ex_t        ex,
  output m_t         m,
  output wb_t        wb
);

  always_comb begin
    ex = EX_BUBBLE;
    m  = M_BUBBLE;
    wb = WB_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        ex.regdst   = 1'b1;
        ex.aluop    = ALUOP_FUNCT;
        wb.regwrite = 1'b1;
      end
      OP_LW: begin
        ex.aluop    = ALUOP_ADD;
        ex.alusrc   = 1'b1;
        m.memread   = 1'b1;
        wb.regwrite = 1'b1;
        wb.memtoreg = 1'b1;
      end
      OP_SW: begin
        ex.aluop    = ALUOP_ADD;
        ex.alusrc   = 1'b1;
        m.memwrite  = 1'b1;
      end
      OP_BEQ: begin
        ex.aluop    = ALUOP_SUB;
        m.branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_control_decoder.sv
// ID-stage main control decoder with registered outputs feeding ID/EX.
//   clk    : pipeline clock (rising edge)
//   rst    : asynchronous active-high reset, clears all outputs
//   flush  : captures a bubble at the edge regardless of opcode
//   opcode : instr[31:26]
//   EX     : {RegDst, ALUOp[1:0], ALUSrc}
//   M      : {Branch, MemRead, MemWrite}
//   WB     : {RegWrite, MemtoReg}
// Outputs come straight from flops: one cycle latency, glitch-free.
module id_control_decoder
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [5:0] opcode,
  output logic [3:0] EX,
  output logic [2:0] M,
  output logic [1:0] WB
);

  ex_t next_ex;
  m_t  next_m;
  wb_t next_wb;

  ctrl_decode_comb u_decode (
    .opcode (opcode),
    .ex     (next_ex),
    .m      (next_m),
    .wb     (next_wb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX <= '0;
      M  <= '0;
      WB <= '0;
    end else if (flush) begin
      EX <= EX_BUBBLE;
      M  <= M_BUBBLE;
      WB <= WB_BUBBLE;
    end else begin
      EX <= next_ex;
      M  <= next_m;
      WB <= next_wb;
    end
  end

endmodule

// File: tb/tb_id_control_decoder.sv
module tb_id_control_decoder;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       flush;
  logic [5:0] opcode;
  logic [3:0] EX;
  logic [2:0] M;
  logic [1:0] WB;

  int unsigned n_checks;
  int unsigned n_fails;

  id_control_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .opcode (opcode),
    .EX     (EX),
    .M      (M),
    .WB     (WB)
  );

  // Clock can be held still so the reset can be shown to act without edges.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference table: {EX[3:0], M[2:0], WB[1:0]} for each supported opcode.
  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'd0:    return 9'b1100_000_10;  // R-type
      6'd35:   return 9'b0001_010_11;  // LW
      6'd43:   return 9'b0001_001_00;  // SW
      6'd4:    return 9'b0010_100_00;  // BEQ
      default: return 9'b0000_000_00;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got EX/M/WB=%b/%b/%b, expected %b/%b/%b @%0t",
               tag, got[8:5], got[4:2], got[1:0], exp[8:5], exp[4:2], exp[1:0], $time);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic fl);
    opcode = op;
    flush  = fl;
    @(posedge clk);
    #1;
    check_val(tag, {EX, M, WB}, fl ? 9'd0 : ref_ctrl(op));
  endtask

  initial begin
    logic [5:0] op;
    logic       fl;
    logic       r;
    logic [5:0] pool [5];

    n_checks = 0;
    n_fails  = 0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    flush    = 1'b0;
    opcode   = 6'd0;

    // Reset with no clock running.
    #1 rst = 1'b1;
    #1 check_val("reset_async", {EX, M, WB}, 9'd0);
    rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    #1 check_val("reset_release", {EX, M, WB}, 9'b1100_000_10);

    // Decode sweep.
    step("dec_lw",    6'b100011, 1'b0);
    step("dec_sw",    6'b101011, 1'b0);
    step("dec_beq",   6'b000100, 1'b0);
    step("dec_other", 6'b111111, 1'b0);
    step("dec_rtype", 6'b000000, 1'b0);

    // Mid-cycle opcode change has no effect until the next edge.
    @(negedge clk);
    opcode = 6'b100011;
    #1 check_val("latency_hold", {EX, M, WB}, 9'b1100_000_10);
    @(posedge clk);
    #1 check_val("latency_load", {EX, M, WB}, 9'b0001_010_11);

    // Flush.
    step("flush_on",  6'b100011, 1'b1);
    step("flush_off", 6'b100011, 1'b0);

    // Async reset between edges, held across edges with flush low.
    @(negedge clk);
    opcode = 6'd0;
    rst = 1'b1;
    #1 check_val("rst_midrun", {EX, M, WB}, 9'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_val("rst_hold", {EX, M, WB}, 9'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    step("rst_exit", 6'd0, 1'b0);

    // Randomized traffic against the reference table.
    pool[0] = 6'b000000;
    pool[1] = 6'b100011;
    pool[2] = 6'b101011;
    pool[3] = 6'b000100;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      pool[4] = 6'($urandom);
      op = pool[$urandom_range(0, 4)];
      fl = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 15) == 0);
      opcode = op;
      flush  = fl;
      rst    = r;
      if (r) begin
        #1 check_val("rnd_rst_async", {EX, M, WB}, 9'd0);
      end
      @(posedge clk);
      #1 check_val("rnd", {EX, M, WB}, (r || fl) ? 9'd0 : ref_ctrl(op));
      if (r) begin
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
